// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-side transmitter.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    GAP     = 2'd2,
    INHIBIT = 2'd3
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;

  // Odd parity over the data byte, optionally inverted for error injection.
  function automatic logic ps2_parity(input logic [7:0] data, input logic bad);
    return (~^data) ^ bad;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte buffer for the PS/2 transmitter: 9-bit entries {bad_par, data}, head peek.
module ps2_tx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [8:0]    wdata_i,
  input  logic          pop_i,
  output logic [8:0]    head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees room.
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: buffered scan codes serialised as 11-bit frames,
// with host clock-inhibit abort/retransmit and parity-error injection.
module ps2_kbd_tx #(
  parameter int CLK_HALF   = 30,
  parameter int GAP_CYCLES = 60,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  input  logic                          in_bad_par,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  input  logic                          ps2_clk_in,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          tx_done
);
  import ps2_pkg::*;

  localparam int TMAX = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_HALF - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          half_q, half_d;       // 0: clock-high half, 1: clock-low half
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic          sync1_q, sync2_q;

  logic [8:0]    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          last_cycle;
  logic          inhibit;
  logic [PS2_FRAME_BITS-1:0] frame;

  ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .wdata_i ({in_bad_par, in_data}),
    .pop_i   (tx_done),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign in_ready   = !fifo_full;
  assign frame      = {1'b1, ps2_parity(head[7:0], head[8]), head[7:0], 1'b0};
  assign last_cycle = (bit_idx_q == LAST_BIT) && half_q && (timer_q == '0);
  // The host can only be seen pulling the clock low while we release it high.
  assign inhibit    = !sync2_q && ps2_clk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= ps2_clk_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty && !inhibit) state_d = SEND;
      SEND: begin
        if (inhibit && (bit_idx_q < LAST_BIT)) state_d = INHIBIT;
        else if (last_cycle)                   state_d = GAP;
      end
      GAP:     if (timer_q == '0) state_d = IDLE;
      INHIBIT: if (sync2_q) state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    busy     = 1'b0;
    tx_done  = 1'b0;
    case (state_q)
      SEND: begin
        ps2_clk  = !half_q;
        ps2_data = frame[bit_idx_q];
        busy     = 1'b1;
        tx_done  = last_cycle;
      end
      GAP, INHIBIT: busy = 1'b1;
      default: ;
    endcase
  end

  // Shared down-counter: half-bit period in SEND, idle length in GAP.
  always_comb begin
    timer_d   = timer_q;
    half_d    = half_q;
    bit_idx_d = bit_idx_q;
    if (state_d != state_q) begin
      timer_d   = (state_d == GAP) ? GAP_LOAD : HALF_LOAD;
      half_d    = 1'b0;
      bit_idx_d = '0;
    end else if ((state_q == SEND) || (state_q == GAP)) begin
      if (timer_q == '0) begin
        timer_d = HALF_LOAD;
        if (state_q == SEND) begin
          half_d = !half_q;
          if (half_q) bit_idx_d = bit_idx_q + 4'd1;
        end
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q   <= HALF_LOAD;
      half_q    <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      timer_q   <= timer_d;
      half_q    <= half_d;
      bit_idx_q <= bit_idx_d;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: frame decoder + expected-frame queue,
// table-driven byte vectors and hand-written inhibit/reset sequences.
module tb_ps2_kbd_tx;

  localparam int CH     = 30;
  localparam int TB_GAP = 60;
  localparam int DEPTH  = 8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_bad_par;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_in;
  logic       busy;
  logic [3:0] level;
  logic       tx_done;

  ps2_kbd_tx #(.CLK_HALF(CH), .GAP_CYCLES(TB_GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_bad_par (in_bad_par),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_in (ps2_clk_in),
    .busy       (busy),
    .level      (level),
    .tx_done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       bad;
    logic       par;   // hand-computed parity bit expected on the wire
  } vec_t;

  vec_t        vec [4];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [10:0] sb_q [$];
  int          start_t [$];
  int          nbits, hi_run, cyc;
  logic        prev_clk, prev_busy;
  logic [10:0] fbits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic b);
    logic p = 1'b1;
    for (int i = 0; i < 8; i++) p = p ^ d[i];
    return {1'b1, p ^ b, d, 1'b0};
  endfunction

  // Decode bus activity: sample data on each falling ps2_clk, drop partial frames after idle.
  task automatic mon_step();
    logic [10:0] exp_f;
    cyc++;
    if (!rst_n) begin
      nbits = 0; hi_run = 0; prev_clk = 1'b1; prev_busy = 1'b0;
      return;
    end
    if (prev_clk && !ps2_clk) begin
      fbits[nbits] = ps2_data;
      nbits++;
      if (nbits == 11) begin
        nbits = 0;
        check("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_f = sb_q.pop_front();
          check("frame", {21'd0, fbits}, {21'd0, exp_f});
        end
      end
    end
    if (ps2_clk) hi_run++; else hi_run = 0;
    if (hi_run > CH) nbits = 0;
    if (!prev_busy && busy) start_t.push_back(cyc);
    prev_clk  = ps2_clk;
    prev_busy = busy;
  endtask

  task automatic cycle();
    @(negedge clk);
    mon_step();
  endtask

  task automatic push(input logic [7:0] d, input logic b, input logic [10:0] f, output logic acc);
    in_valid   = 1'b1;
    in_data    = d;
    in_bad_par = b;
    acc        = in_ready;
    if (acc) sb_q.push_back(f);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy || level != 0) && n < bound) begin cycle(); n++; end
    check("idle_reached", 32'(!busy && level == 0), 1);
  endtask

  task automatic wait_busy(input int bound, input string name);
    int n = 0;
    while (!busy && n < bound) begin cycle(); n++; end
    check(name, busy, 1);
  endtask

  task automatic wait_done(input int bound, input string name);
    int n = 0;
    while (!tx_done && n < bound) begin cycle(); n++; end
    check(name, tx_done, 1);
    cycle();
  endtask

  initial begin
    int   c, g, n, lows, dlows, td, lvl0;
    logic acc;
    logic [7:0] d;

    vec[0] = '{8'h1C, 1'b0, 1'b0};
    vec[1] = '{8'hF0, 1'b0, 1'b1};
    vec[2] = '{8'hF0, 1'b1, 1'b0};
    vec[3] = '{8'h5A, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_bad_par = 1'b0; ps2_clk_in = 1'b1;
    cyc = 0; nbits = 0; hi_run = 0; prev_clk = 1'b1; prev_busy = 1'b0; fbits = '0;
    repeat (3) cycle();
    check("rst_clk", ps2_clk, 1);
    check("rst_data", ps2_data, 1);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_done", tx_done, 0);
    rst_n = 1'b1;
    cycle();

    // Single bytes: latency, frame length, parity and gap length.
    for (int i = 0; i < 3; i++) begin
      wait_idle(2000);
      push(vec[i].data, vec[i].bad, {1'b1, vec[i].par, vec[i].data, 1'b0}, acc);
      check("vec_acc", acc, 1);
      check("lat_level", level, 1);
      check("lat_idle", busy, 0);
      cycle();
      check("start_busy", busy, 1);
      check("start_clk", ps2_clk, 1);
      check("start_data", ps2_data, 0);
      c = 1;
      while (!tx_done && c < 2000) begin cycle(); c++; end
      check("frame_len", c, 22 * CH);
      cycle();
      check("pop_level", level, 0);
      g = 0;
      while (busy && g < 1000) begin g++; cycle(); end
      check("gap_len", g, TB_GAP);
    end

    // Burst of 9 into an 8-deep buffer.
    wait_idle(2000);
    start_t.delete();
    for (int i = 0; i < 9; i++) begin
      d = 8'h30 + 8'(i);
      if (i == 8) begin
        check("full_level", level, DEPTH);
        check("full_ready", in_ready, 0);
      end
      push(d, i[0], mk_frame(d, i[0]), acc);
      check("burst_acc", acc, 32'(i < 8));
    end
    n = 0; acc = 1'b0;
    while (!acc && n < 2000) begin
      push(8'h38, 1'b0, mk_frame(8'h38, 1'b0), acc);
      n++;
    end
    check("burst_retry", acc, 1);
    n = 0;
    while ((sb_q.size() != 0 || busy || level != 0) && n < 10000) begin cycle(); n++; end
    check("burst_drain", sb_q.size(), 0);
    check("burst_starts", start_t.size(), 9);
    if (start_t.size() >= 3) begin
      check("spacing_1", start_t[1] - start_t[0], 22 * CH + TB_GAP + 1);
      check("spacing_2", start_t[2] - start_t[1], 22 * CH + TB_GAP + 1);
    end

    // Host inhibit during bit 4: abort, hold, resend from the start bit.
    wait_idle(2000);
    push(vec[3].data, vec[3].bad, {1'b1, vec[3].par, vec[3].data, 1'b0}, acc);
    wait_busy(10, "inh_start");
    repeat (4 * 2 * CH) cycle();
    ps2_clk_in = 1'b0;
    lvl0 = int'(level);
    repeat (3) cycle();
    check("inh_clk", ps2_clk, 1);
    check("inh_data", ps2_data, 1);
    check("inh_busy", busy, 1);
    lows = 0; dlows = 0; td = 0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (!ps2_clk) lows++;
      if (!ps2_data) dlows++;
      if (tx_done) td++;
    end
    check("inh_clk_held", lows, 0);
    check("inh_data_held", dlows, 0);
    check("inh_no_done", td, 0);
    check("inh_level", level, lvl0);
    ps2_clk_in = 1'b1;
    wait_done(2000, "inh_resend_done");
    check("inh_sb_empty", sb_q.size(), 0);

    // Inhibit during bit 10: frame completes, next byte waits for release.
    wait_idle(2000);
    push(8'h12, 1'b0, mk_frame(8'h12, 1'b0), acc);
    push(8'h34, 1'b0, mk_frame(8'h34, 1'b0), acc);
    wait_busy(10, "b10_start");
    repeat (20 * CH) cycle();
    ps2_clk_in = 1'b0;
    wait_done(100, "b10_done");
    lows = 0;
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (!ps2_clk) lows++;
    end
    check("b10_blocked_clk", lows, 0);
    check("b10_blocked_busy", busy, 0);
    check("b10_blocked_level", level, 1);
    ps2_clk_in = 1'b1;
    wait_done(2000, "b10_next_done");
    check("b10_sb_empty", sb_q.size(), 0);

    // Reset mid-frame flushes everything.
    wait_idle(2000);
    push(8'h76, 1'b0, mk_frame(8'h76, 1'b0), acc);
    push(8'h77, 1'b0, mk_frame(8'h77, 1'b0), acc);
    repeat (99) cycle();
    check("rst_pre_level", level, 2);
    check("rst_pre_clk", ps2_clk, 0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("rst_mid_clk", ps2_clk, 1);
    check("rst_mid_data", ps2_data, 1);
    check("rst_mid_level", level, 0);
    check("rst_mid_busy", busy, 0);
    sb_q.delete();
    repeat (5) cycle();
    check("rst_post_busy", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
